seg7_mux_ctrl: RTL and testbench
================================

SEG7_MUX_CTRL -- requirements
Module: seg7_mux_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 SHALL have parameter DIGIT_PERIOD, default 120000, clk cycles each digit is selected (5 ms at 24 MHz).
REQ-003 SHALL have parameter BLANK_CYCLES, default 16, anti-ghost off-time at start of each digit slot (< DIGIT_PERIOD).
REQ-004 SHALL have parameter ANODE_ACTIVE_LOW, default 1, polarity of anode outputs.
REQ-005 SHALL have parameter SEG_ACTIVE_LOW, default 0, polarity of segment and dp outputs.
REQ-006 Port list (name direction width meaning): clk input 1, clock.
REQ-007 reset input 1: synchronous, active-low reset.
REQ-008 value input 4*NUM_DIGITS: hex nibbles; nibble 0 (bits 3:0) is the rightmost digit.
REQ-009 dp input NUM_DIGITS: decimal point per digit, 1 = lit.
REQ-010 load input 1: one-cycle strobe capturing value and dp into the shadow register.
REQ-011 brightness input 4: PWM duty, 0 = 1/16 ... 15 = full on.
REQ-012 anode output NUM_DIGITS: digit enables, polarity per ANODE_ACTIVE_LOW.
REQ-013 segments output 7: {A,B,C,D,E,F,G}, polarity per SEG_ACTIVE_LOW.
REQ-014 seg_dp output 1: decimal point segment.
REQ-015 frame_tick output 1: one-cycle pulse at each frame start.

Function
REQ-016 Slot counter SHALL count 0..DIGIT_PERIOD-1 and wrap; at the wrap, digit index SHALL advance by one, wrapping NUM_DIGITS-1 -> 0.
REQ-017 Load SHALL update the shadow register on the cycle after load is sampled high; the display register SHALL copy the shadow only when the index wraps to 0 (tear-free frames).
REQ-018 If load coincides with the index wrap, the display register SHALL take the newly loaded value directly.
REQ-019 frame_tick SHALL be high for exactly the one cycle in which the index is 0 and the slot counter is 0.
REQ-020 While the slot counter < BLANK_CYCLES, all anodes SHALL be inactive; segments and seg_dp SHALL be registered with the decode of the current digit at slot counter == BLANK_CYCLES-1.
REQ-021 From slot counter >= BLANK_CYCLES, only the selected anode SHALL be active, and only while the free-running 4-bit pwm counter <= brightness.
REQ-022 Decode SHALL be standard hex (active-high view): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-023 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-024 With reset low at a clk edge: slot counter, index, pwm counter, shadow and display registers = 0; anode all inactive; segments and seg_dp inactive; frame_tick = 0.
REQ-025 Reset asserted mid-slot or mid-frame SHALL take effect at the next edge with no completion of the slot; the first cycle after release SHALL be slot 0 of digit 0 with frame_tick = 1.

Configuration
REQ-026 With macro SEG7_LEADING_ZERO_BLANK_EN defined, digits above the most significant nonzero nibble of the display register SHALL keep their anode inactive (digit 0 always shown; dp=1 on a digit forces it and all lower digits visible).
REQ-027 Without SEG7_LEADING_ZERO_BLANK_EN, every digit SHALL be displayed, including leading zeros.

Verification (NUM_DIGITS=4, DIGIT_PERIOD=8, BLANK_CYCLES=2, default polarities)
REQ-028 Release reset, brightness=15, load value=16'h12AF -> anode cycles 1110,1101,1011,0111 (digit 0 first), 6 on-cycles per 8-cycle slot, segments 1000111,1110111,1101101,0110000; frame_tick every 32 cycles.
REQ-029 Load 16'h0000 mid-frame -> digits keep the old value until the next frame_tick, then all show 1111110.
REQ-030 brightness=0 -> selected anode active only in cycles where pwm counter == 0; anodes 1111 during both blank cycles of every slot.
REQ-031 load asserted on the index wrap cycle with value 16'h8888 -> the new frame shows 8 (1111111) on all digits immediately.
REQ-032 With SEG7_LEADING_ZERO_BLANK_EN, value 16'h0042 -> digits 3 and 2 anode 1 throughout; value 16'h0000 -> only digit 0 lit, showing 0; dp=4'b0100 with 16'h0042 -> digit 2 lit.
REQ-033 Reset pulsed low for one cycle mid-slot of digit 2 -> next cycle all outputs at reset values, then digit 0 slot 0 with frame_tick = 1.

Source files
------------

// File: rtl/seg7_mux_ctrl_if.sv
// Host/display bundle for seg7_mux_ctrl: shadow-load inputs and multiplexed display drive.
interface seg7_mux_ctrl_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    load;
    logic [3:0]              brightness;
    logic [NUM_DIGITS-1:0]   anode;
    logic [6:0]              segments;
    logic                    seg_dp;
    logic                    frame_tick;

    modport master (
        output value, dp, load, brightness,
        input  anode, segments, seg_dp, frame_tick
    );

    modport slave (
        input  value, dp, load, brightness,
        output anode, segments, seg_dp, frame_tick
    );
endinterface

// File: rtl/seg7_mux_ctrl.sv
// Multiplexed 7-segment driver: tear-free shadow/display registers, anti-ghost blanking, PWM dimming.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero nibble.
module seg7_mux_ctrl #(
    parameter int unsigned NUM_DIGITS       = 4,
    parameter int unsigned DIGIT_PERIOD     = 120000,
    parameter int unsigned BLANK_CYCLES     = 16,
    parameter bit          ANODE_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_ACTIVE_LOW   = 1'b0
) (
    input logic              clk,
    input logic              reset,
    seg7_mux_ctrl_if.slave   bus
);

    localparam int unsigned SlotW = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
    localparam int unsigned IdxW  = $clog2(NUM_DIGITS);
    localparam logic [SlotW-1:0] SlotLast   = SlotW'(DIGIT_PERIOD - 1);
    localparam logic [SlotW-1:0] SlotBlank  = SlotW'(BLANK_CYCLES);
    localparam logic [SlotW-1:0] SlotDecode = SlotW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IdxW-1:0]  IdxLast    = IdxW'(NUM_DIGITS - 1);

    logic [SlotW-1:0]        slot_q, slot_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [3:0]              pwm_q, pwm_d;
    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d, disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d, sel_onehot, visible;
    logic [6:0]              seg_q, seg_d;
    logic                    seg_dp_q, seg_dp_d, frame_tick_q, frame_tick_d;
    logic                    slot_wrap, frame_wrap;
    logic [3:0]              cur_nibble;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic lz_seen;

    // Scan from the top digit down; a nonzero nibble or lit dp unmasks itself and everything below.
    always_comb begin
        lz_seen = 1'b0;
        visible = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            lz_seen    = lz_seen | (disp_val_q[4*i +: 4] != 4'h0) | disp_dp_q[i];
            visible[i] = lz_seen | (i == 0);
        end
    end
`else
    assign visible = '1;
`endif

    always_comb begin
        slot_wrap  = (slot_q == SlotLast);
        frame_wrap = slot_wrap && (idx_q == IdxLast);

        slot_d = slot_wrap ? '0 : slot_q + SlotW'(1);
        idx_d  = idx_q;
        if (slot_wrap) begin
            idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
        end
        pwm_d = pwm_q + 4'd1;

        shadow_val_d = bus.load ? bus.value : shadow_val_q;
        shadow_dp_d  = bus.load ? bus.dp : shadow_dp_q;

        // A load landing on the frame wrap bypasses the shadow so the new frame shows it at once.
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        if (frame_wrap) begin
            disp_val_d = bus.load ? bus.value : shadow_val_q;
            disp_dp_d  = bus.load ? bus.dp : shadow_dp_q;
        end

        cur_nibble = disp_val_q[{idx_q, 2'b00} +: 4];
        seg_d      = seg_q;
        seg_dp_d   = seg_dp_q;
        if (slot_q == SlotDecode) begin
            seg_d    = hex_decode(cur_nibble) ^ {7{SEG_ACTIVE_LOW}};
            seg_dp_d = disp_dp_q[idx_q] ^ SEG_ACTIVE_LOW;
        end

        sel_onehot = '0;
        if ((slot_q >= SlotBlank) && (pwm_q <= bus.brightness) && visible[idx_q]) begin
            sel_onehot[idx_q] = 1'b1;
        end
        anode_d      = sel_onehot ^ {NUM_DIGITS{ANODE_ACTIVE_LOW}};
        frame_tick_d = (slot_q == '0) && (idx_q == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_q       <= '0;
            idx_q        <= '0;
            pwm_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            anode_q      <= {NUM_DIGITS{ANODE_ACTIVE_LOW}};
            seg_q        <= {7{SEG_ACTIVE_LOW}};
            seg_dp_q     <= SEG_ACTIVE_LOW;
            frame_tick_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            idx_q        <= idx_d;
            pwm_q        <= pwm_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            anode_q      <= anode_d;
            seg_q        <= seg_d;
            seg_dp_q     <= seg_dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.anode      = anode_q;
    assign bus.segments   = seg_q;
    assign bus.seg_dp     = seg_dp_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_mux_ctrl.sv
// Randomised self-checking bench for seg7_mux_ctrl (4 digits, 8-cycle slots, 2 blank cycles).
module tb_seg7_mux_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    seg7_mux_ctrl_if #(.NUM_DIGITS(4)) bus ();

    seg7_mux_ctrl #(
        .NUM_DIGITS      (4),
        .DIGIT_PERIOD    (8),
        .BLANK_CYCLES    (2),
        .ANODE_ACTIVE_LOW(1'b1),
        .SEG_ACTIVE_LOW  (1'b0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    logic [3:0] lit_an [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] lit_seg [4] = '{7'b1000111, 7'b1110111, 7'b1101101, 7'b0110000};

    // Reference: time t since reset gives slot = t%8, digit = (t/8)%4, pwm = t%16, frame = t/32.
    int         t = 0;
    int         t_obs = 0;
    logic [15:0] shadow_m = '0, disp_m = '0;
    logic [3:0]  sdp_m = '0, ddp_m = '0;
    logic [6:0]  seg_m = '0;
    logic        segdp_m = 1'b0;
    logic [3:0]  exp_anode;
    logic [6:0]  exp_seg;
    logic        exp_segdp, exp_ft;

    function automatic bit shown(input int d);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (d == 0) return 1'b1;
        for (int j = d; j < 4; j++) begin
            if (disp_m[4*j +: 4] != 4'h0 || ddp_m[j]) return 1'b1;
        end
        return 1'b0;
`else
        return d >= 0;
`endif
    endfunction

    task automatic model_step();
        int slot, dig;
        t_obs = t;
        if (!reset) begin
            t = 0; shadow_m = '0; disp_m = '0; sdp_m = '0; ddp_m = '0;
            seg_m = '0; segdp_m = 1'b0;
            exp_anode = 4'hF; exp_seg = '0; exp_segdp = 1'b0; exp_ft = 1'b0;
            return;
        end
        slot = t % 8;
        dig  = (t / 8) % 4;
        exp_ft = (t % 32 == 0);
        if (slot == 1) begin
            seg_m   = hex_tab[disp_m[4*dig +: 4]];
            segdp_m = ddp_m[dig];
        end
        exp_seg   = seg_m;
        exp_segdp = segdp_m;
        exp_anode = 4'hF;
        if (slot >= 2 && (t % 16) <= int'(bus.brightness) && shown(dig)) exp_anode[dig] = 1'b0;
        if (t % 32 == 31) begin
            disp_m = bus.load ? bus.value : shadow_m;
            ddp_m  = bus.load ? bus.dp : sdp_m;
        end
        if (bus.load) begin
            shadow_m = bus.value;
            sdp_m    = bus.dp;
        end
        t++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.load = 1'b0; bus.value = '0; bus.dp = '0; bus.brightness = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({bus.anode, bus.segments, bus.seg_dp, bus.frame_tick} !== {4'hF, 7'h00, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL reset got an=%b seg=%b dp=%b ft=%b want an=1111 seg=0000000 dp=0 ft=0",
                         bus.anode, bus.segments, bus.seg_dp, bus.frame_tick);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        int on_cnt = 0;
        int ticks = 0;
        int s, d;
        bus.brightness = 4'hF; bus.value = 16'h12AF; bus.dp = 4'b0000; bus.load = 1'b1;
        for (int i = 0; i < 96; i++) begin
            tick();
            bus.load = 1'b0;
            vectors++;
            if ({bus.anode, bus.segments, bus.seg_dp, bus.frame_tick} !==
                {exp_anode, exp_seg, exp_segdp, exp_ft}) begin
                miscompares++;
                $display("FAIL basic t=%0d got %b/%b/%b/%b want %b/%b/%b/%b", t_obs, bus.anode,
                         bus.segments, bus.seg_dp, bus.frame_tick, exp_anode, exp_seg, exp_segdp, exp_ft);
            end
            s = t_obs % 8; d = (t_obs / 8) % 4;
            if (bus.frame_tick) ticks++;
            if (t_obs >= 64) begin
                if (s >= 2) begin
                    vectors++;
                    if (bus.anode !== lit_an[d] || bus.segments !== lit_seg[d]) begin
                        miscompares++;
                        $display("FAIL basic_digit t=%0d got an=%b seg=%b want an=%b seg=%b", t_obs,
                                 bus.anode, bus.segments, lit_an[d], lit_seg[d]);
                    end
                end
                if (bus.anode != 4'hF) on_cnt++;
                if (s == 7) begin
                    vectors++;
                    if (on_cnt != 6) begin
                        miscompares++;
                        $display("FAIL basic_on_cycles digit=%0d got %0d want 6", d, on_cnt);
                    end
                    on_cnt = 0;
                end
            end
        end
        vectors++;
        if (ticks != 3) begin
            miscompares++;
            $display("FAIL basic_frame_ticks got %0d want 3", ticks);
        end
    endtask

    task automatic test_load_mid_frame();
        int s, d;
        for (int i = 0; i < 64; i++) begin
            bus.load  = (t == 100);
            bus.value = 16'h0000;
            tick();
            bus.load = 1'b0;
            vectors++;
            if ({bus.anode, bus.segments, bus.seg_dp, bus.frame_tick} !==
                {exp_anode, exp_seg, exp_segdp, exp_ft}) begin
                miscompares++;
                $display("FAIL load_mid t=%0d got %b/%b/%b/%b want %b/%b/%b/%b", t_obs, bus.anode,
                         bus.segments, bus.seg_dp, bus.frame_tick, exp_anode, exp_seg, exp_segdp, exp_ft);
            end
            s = t_obs % 8; d = (t_obs / 8) % 4;
            if (t_obs < 128 && s >= 2) begin
                vectors++;
                if (bus.segments !== lit_seg[d]) begin
                    miscompares++;
                    $display("FAIL load_mid_old t=%0d got %b want %b", t_obs, bus.segments, lit_seg[d]);
                end
            end
            if (t_obs >= 128 && s >= 1) begin
                vectors++;
                if (bus.segments !== 7'b1111110) begin
                    miscompares++;
                    $display("FAIL load_mid_new t=%0d got %b want 1111110", t_obs, bus.segments);
                end
            end
        end
    endtask

    task automatic test_dim();
        bus.brightness = 4'h0;
        for (int i = 0; i < 32; i++) begin
            tick();
            vectors++;
            if ({bus.anode, bus.segments, bus.seg_dp, bus.frame_tick} !==
                {exp_anode, exp_seg, exp_segdp, exp_ft} || bus.anode !== 4'hF) begin
                miscompares++;
                $display("FAIL dim t=%0d got %b/%b/%b/%b want %b/%b/%b/%b", t_obs, bus.anode,
                         bus.segments, bus.seg_dp, bus.frame_tick, exp_anode, exp_seg, exp_segdp, exp_ft);
            end
        end
    endtask

    task automatic test_wrap_load();
        bus.brightness = 4'hF;
        for (int i = 0; i < 64; i++) begin
            bus.load  = (t % 32 == 31);
            bus.value = 16'h8888;
            tick();
            bus.load = 1'b0;
            vectors++;
            if ({bus.anode, bus.segments, bus.seg_dp, bus.frame_tick} !==
                {exp_anode, exp_seg, exp_segdp, exp_ft}) begin
                miscompares++;
                $display("FAIL wrap_load t=%0d got %b/%b/%b/%b want %b/%b/%b/%b", t_obs, bus.anode,
                         bus.segments, bus.seg_dp, bus.frame_tick, exp_anode, exp_seg, exp_segdp, exp_ft);
            end
            if (t_obs >= 224 && t_obs % 8 >= 1) begin
                vectors++;
                if (bus.segments !== 7'b1111111) begin
                    miscompares++;
                    $display("FAIL wrap_load_eight t=%0d got %b want 1111111", t_obs, bus.segments);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus.load  = ($urandom_range(0, 7) == 0);
            bus.value = 16'($urandom);
            bus.dp    = 4'($urandom);
            if ($urandom_range(0, 31) == 0) bus.brightness = 4'($urandom);
            tick();
            bus.load = 1'b0;
            vectors++;
            if ({bus.anode, bus.segments, bus.seg_dp, bus.frame_tick} !==
                {exp_anode, exp_seg, exp_segdp, exp_ft}) begin
                miscompares++;
                $display("FAIL random t=%0d got %b/%b/%b/%b want %b/%b/%b/%b", t_obs, bus.anode,
                         bus.segments, bus.seg_dp, bus.frame_tick, exp_anode, exp_seg, exp_segdp, exp_ft);
            end
        end
        bus.dp = 4'b0000;
    endtask

    task automatic test_reset_mid();
        bus.brightness = 4'hF;
        for (int i = 0; i < 64 && (t % 32) != 20; i++) tick();
        reset = 1'b0;
        tick();
        vectors++;
        if ({bus.anode, bus.segments, bus.seg_dp, bus.frame_tick} !== {4'hF, 7'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid got an=%b seg=%b dp=%b ft=%b want 1111/0000000/0/0",
                     bus.anode, bus.segments, bus.seg_dp, bus.frame_tick);
        end
        reset = 1'b1;
        tick();
        vectors++;
        if (bus.frame_tick !== 1'b1 || bus.anode !== 4'hF ||
            {bus.anode, bus.segments, bus.seg_dp, bus.frame_tick} !==
            {exp_anode, exp_seg, exp_segdp, exp_ft}) begin
            miscompares++;
            $display("FAIL reset_release got an=%b seg=%b ft=%b want an=1111 seg=%b ft=1",
                     bus.anode, bus.segments, bus.frame_tick, exp_seg);
        end
    endtask

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    task automatic test_leading_zero();
        int s, d;
        bit bad;
        bus.brightness = 4'hF;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 32 && (t % 32) != 0; i++) tick();
            bus.value = (k == 1) ? 16'h0000 : 16'h0042;
            bus.dp    = (k == 2) ? 4'b0100 : 4'b0000;
            bus.load  = 1'b1;
            for (int i = 0; i < 64; i++) begin
                tick();
                bus.load = 1'b0;
                vectors++;
                if ({bus.anode, bus.segments, bus.seg_dp, bus.frame_tick} !==
                    {exp_anode, exp_seg, exp_segdp, exp_ft}) begin
                    miscompares++;
                    $display("FAIL lzb t=%0d got %b/%b/%b/%b want %b/%b/%b/%b", t_obs, bus.anode,
                             bus.segments, bus.seg_dp, bus.frame_tick, exp_anode, exp_seg, exp_segdp,
                             exp_ft);
                end
                if (i >= 32) begin
                    s = t_obs % 8; d = (t_obs / 8) % 4;
                    bad = 1'b0;
                    if (k == 0) bad = (bus.anode[3:2] !== 2'b11);
                    if (k == 1) bad = (bus.anode[3:1] !== 3'b111) ||
                                      (d == 0 && s >= 2 && bus.anode !== 4'b1110);
                    if (k == 2 && d == 2 && s >= 2) bad = (bus.anode !== 4'b1011);
                    vectors++;
                    if (bad) begin
                        miscompares++;
                        $display("FAIL lzb_case%0d t=%0d got an=%b", k, t_obs, bus.anode);
                    end
                end
            end
        end
        bus.dp = 4'b0000;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_load_mid_frame();
        test_dim();
        test_wrap_load();
        test_random();
        test_reset_mid();
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        test_leading_zero();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0d", t);
        $fatal(1, "timeout");
    end

endmodule
